fc_train_ctrl: RTL and testbench

FC_TRAIN_CTRL -- requirements
Module: fc_train_ctrl

---
 rtl/fc_ctrl_pkg.sv | 34 +++
 rtl/fc_port_mux.sv | 31 +++
 rtl/fc_train_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_fc_train_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_ctrl_pkg.sv
// Shared types and constants for the FC training-step controller:
// state enum, memory bank-select encodings and default geometry.
package fc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FC1   = 3'd2,
    ST_FC2   = 3'd3,
    ST_LABEL = 3'd4,
    ST_BACK  = 3'd5,
    ST_FIN   = 3'd6
  } fc_state_e;

  // {fc1_com_end, fc2_com_end}
  localparam logic [1:0] BANK_FRONT = 2'b00;
  localparam logic [1:0] BANK_MID   = 2'b10;
  localparam logic [1:0] BANK_BACK  = 2'b11;

  localparam int DEF_FRT_CELL    = 32;
  localparam int DEF_MID_CELL    = 20;
  localparam int DEF_BCK_CELL    = 10;
  localparam int DEF_TIMEOUT_CYC = 4096;
  localparam logic [15:0] DEF_TARGET_VAL = 16'h0600;

  function automatic logic [1:0] bank_sel(input fc_state_e st);
    case (st)
      ST_FC2:                    return BANK_MID;
      ST_LABEL, ST_BACK, ST_FIN: return BANK_BACK;
      default:                   return BANK_FRONT;
    endcase
  endfunction

endpackage

// File: rtl/fc_port_mux.sv
// FC memory port arbitration: the controller's registered write port owns
// the memory except during the FC1/FC2 engine phases.
module fc_port_mux
  import fc_ctrl_pkg::*;
(
  input  fc_state_e   state,
  input  logic        ctl_we,
  input  logic [15:0] ctl_data,
  input  logic [15:0] ctl_addr,
  input  logic        eng_we,
  input  logic [15:0] eng_data,
  input  logic [15:0] eng_addr,
  output logic        mem_we,
  output logic [15:0] mem_data,
  output logic [15:0] mem_addr
);

  // The last conv beat is written in the first FC1 cycle; the controller
  // port keeps priority while it drains, then the engine passes through.
  always_comb begin
    mem_we   = ctl_we;
    mem_data = ctl_data;
    mem_addr = ctl_addr;
    if ((state == ST_FC1 || state == ST_FC2) && !ctl_we) begin
      mem_we   = eng_we;
      mem_data = eng_data;
      mem_addr = eng_addr;
    end
  end

endmodule

// File: rtl/fc_train_ctrl.sv
// Sequencer for one FC training step: load conv results, run the two FC
// engines, write the one-hot target vector, then collect the propagated
// error beats for the conv stage.
// Optional watchdog on FC1/FC2/BACK: define FC_CTRL_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | accepting FRT_CELL conv beats into FC memory bank 00
//   FC1   | first FC engine running, engine owns memory port
//   FC2   | second FC engine running, bank 10
//   LABEL | writing BCK_CELL target words into bank 11
//   BACK  | backward pass, capturing error beats in index order
//   FIN   | one-cycle completion, done pulse
module fc_train_ctrl
  import fc_ctrl_pkg::*;
#(
  parameter int          FRT_CELL    = DEF_FRT_CELL,
  parameter int          MID_CELL    = DEF_MID_CELL,
  parameter int          BCK_CELL    = DEF_BCK_CELL,
  parameter logic [15:0] TARGET_VAL  = DEF_TARGET_VAL,
  parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  label,
  input  logic        conv_valid,
  input  logic [15:0] conv_data,
  output logic        conv_ready,
  output logic        fc1_start,
  output logic        fc2_start,
  input  logic        fc1_done,
  input  logic        fc2_done,
  input  logic        eng_we,
  input  logic [15:0] eng_data,
  input  logic [15:0] eng_addr,
  output logic        mem_we,
  output logic [15:0] mem_data,
  output logic [15:0] mem_addr,
  output logic        fc1_com_end,
  output logic        fc2_com_end,
  output logic        bck_prop_start,
  input  logic        fc_bck_prop_end,
  input  logic [15:0] fc_err_prop,
  input  logic [15:0] fc_err_addr,
  output logic        err_valid,
  output logic [15:0] err_data,
  output logic [15:0] err_addr,
  output logic        busy,
  output logic        done,
  output logic        reject,
  output logic        timeout
);

  localparam logic [15:0] FRT_LAST = 16'(FRT_CELL - 1);
  localparam logic [15:0] FRT_END  = 16'(FRT_CELL);
  localparam logic [15:0] BCK_LAST = 16'(BCK_CELL - 1);
  localparam logic [15:0] BCK_LIM  = 16'(BCK_CELL);
  localparam logic [15:0] LBL_BASE = 16'(2 * BCK_CELL);

  // The label is 4 bits wide, so the output layer cannot exceed 16 cells.
  if (FRT_CELL < 1 || MID_CELL < 1 || BCK_CELL < 1 || BCK_CELL > 16 ||
      TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("fc_train_ctrl: invalid cell count or timeout parameter");
  end

  fc_state_e   state, state_nx;
  logic [15:0] beat_cnt, lbl_cnt, err_cnt;
  logic [3:0]  label_q;
  logic        label_ok;
  logic        ctl_we;
  logic [15:0] ctl_data, ctl_addr;
  logic        wd_expired;

  assign label_ok = ({12'b0, label} < BCK_LIM);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode and state-level outputs.
  always_comb begin
    state_nx       = state;
    conv_ready     = 1'b0;
    bck_prop_start = 1'b0;
    done           = 1'b0;
    busy           = (state != ST_IDLE);
    {fc1_com_end, fc2_com_end} = bank_sel(state);
    case (state)
      ST_IDLE: begin
        if (start && label_ok) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        conv_ready = 1'b1;
        if (conv_valid && beat_cnt == FRT_LAST) state_nx = ST_FC1;
      end
      ST_FC1: begin
        if (fc1_done)        state_nx = ST_FC2;
        else if (wd_expired) state_nx = ST_IDLE;
      end
      ST_FC2: begin
        if (fc2_done)        state_nx = ST_LABEL;
        else if (wd_expired) state_nx = ST_IDLE;
      end
      ST_LABEL: begin
        if (lbl_cnt == BCK_LAST) state_nx = ST_BACK;
      end
      ST_BACK: begin
        bck_prop_start = 1'b1;
        if (fc_bck_prop_end && err_cnt == FRT_END) state_nx = ST_FIN;
        else if (wd_expired)                       state_nx = ST_IDLE;
      end
      ST_FIN: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Registered write port, error capture, counters and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt  <= '0;
      lbl_cnt   <= '0;
      err_cnt   <= '0;
      label_q   <= '0;
      ctl_we    <= 1'b0;
      ctl_data  <= '0;
      ctl_addr  <= '0;
      err_valid <= 1'b0;
      err_data  <= '0;
      err_addr  <= '0;
      reject    <= 1'b0;
      fc1_start <= 1'b0;
      fc2_start <= 1'b0;
    end else begin
      ctl_we    <= 1'b0;
      ctl_data  <= '0;
      ctl_addr  <= '0;
      err_valid <= 1'b0;
      err_data  <= '0;
      err_addr  <= '0;
      reject    <= (state == ST_IDLE) && start && !label_ok;
      fc1_start <= (state != ST_FC1) && (state_nx == ST_FC1);
      fc2_start <= (state != ST_FC2) && (state_nx == ST_FC2);
      case (state)
        ST_IDLE: begin
          beat_cnt <= '0;
          lbl_cnt  <= '0;
          err_cnt  <= '0;
          if (start && label_ok) label_q <= label;
        end
        ST_LOAD: begin
          if (conv_valid) begin
            ctl_we   <= 1'b1;
            ctl_data <= conv_data;
            ctl_addr <= beat_cnt;
            beat_cnt <= beat_cnt + 16'd1;
          end
        end
        ST_LABEL: begin
          ctl_we   <= 1'b1;
          ctl_addr <= LBL_BASE + lbl_cnt;
          ctl_data <= (lbl_cnt == {12'b0, label_q}) ? TARGET_VAL : 16'h0000;
          lbl_cnt  <= lbl_cnt + 16'd1;
        end
        ST_BACK: begin
          // Beats past the last index are not captured.
          if (err_cnt != FRT_END && fc_err_addr == err_cnt) begin
            err_valid <= 1'b1;
            err_data  <= fc_err_prop;
            err_addr  <= err_cnt;
            err_cnt   <= err_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FC_CTRL_TIMEOUT_EN
  localparam logic [31:0] WD_LOAD = 32'(TIMEOUT_CYC - 1);

  logic [31:0] wd_cnt;
  logic        wd_state;
  logic        timeout_q;

  assign wd_state   = (state == ST_FC1) || (state == ST_FC2) || (state == ST_BACK);
  assign wd_expired = wd_state && (wd_cnt == '0);
  assign timeout    = timeout_q;

  // Watchdog down-counter, reloaded on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_expired && (state_nx == ST_IDLE);
      if (state_nx != state)             wd_cnt <= WD_LOAD;
      else if (wd_state && wd_cnt != '0) wd_cnt <= wd_cnt - 32'd1;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign timeout    = 1'b0;
`endif

  fc_port_mux u_port_mux (
    .state    (state),
    .ctl_we   (ctl_we),
    .ctl_data (ctl_data),
    .ctl_addr (ctl_addr),
    .eng_we   (eng_we),
    .eng_data (eng_data),
    .eng_addr (eng_addr),
    .mem_we   (mem_we),
    .mem_data (mem_data),
    .mem_addr (mem_addr)
  );

endmodule

// File: tb/tb_fc_train_ctrl.sv
// Randomized bench for fc_train_ctrl. Expected memory writes and error
// beats are queued from the step rules as stimulus is generated; a negedge
// monitor checks every DUT write/error beat against those queues.
module tb_fc_train_ctrl;

  localparam int FRT = 32;
  localparam int BCK = 10;
  localparam int TO  = 100;
  localparam logic [15:0] TGT = 16'h0600;

  logic        clk = 1'b0;
  logic        reset, start, conv_valid, fc1_done, fc2_done, eng_we, fc_bck_prop_end;
  logic [3:0]  label;
  logic [15:0] conv_data, eng_data, eng_addr, fc_err_prop, fc_err_addr;
  logic        conv_ready, fc1_start, fc2_start, mem_we, fc1_com_end, fc2_com_end;
  logic        bck_prop_start, err_valid, busy, done, reject, timeout;
  logic [15:0] mem_data, mem_addr, err_data, err_addr;

  fc_train_ctrl #(
    .FRT_CELL(FRT), .MID_CELL(20), .BCK_CELL(BCK), .TARGET_VAL(TGT), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .label(label),
    .conv_valid(conv_valid), .conv_data(conv_data), .conv_ready(conv_ready),
    .fc1_start(fc1_start), .fc2_start(fc2_start), .fc1_done(fc1_done), .fc2_done(fc2_done),
    .eng_we(eng_we), .eng_data(eng_data), .eng_addr(eng_addr),
    .mem_we(mem_we), .mem_data(mem_data), .mem_addr(mem_addr),
    .fc1_com_end(fc1_com_end), .fc2_com_end(fc2_com_end),
    .bck_prop_start(bck_prop_start), .fc_bck_prop_end(fc_bck_prop_end),
    .fc_err_prop(fc_err_prop), .fc_err_addr(fc_err_addr),
    .err_valid(err_valid), .err_data(err_data), .err_addr(err_addr),
    .busy(busy), .done(done), .reject(reject), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0, reject_cnt = 0, timeout_cnt = 0, err_seen = 0;
  bit mon_en = 1'b0;
  logic [33:0] exp_wr[$];   // {bank, addr, data}
  logic [31:0] exp_err[$];  // {addr, data}
  logic [15:0] ram2 [0:63];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every DUT write / error beat must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we) begin
        if (exp_wr.size() == 0) chk("unexpected_write", {mem_we, mem_addr}, 17'h0);
        else chk("mem_write", {fc1_com_end, fc2_com_end, mem_addr, mem_data}, exp_wr.pop_front());
        if ({fc1_com_end, fc2_com_end} == 2'b11) ram2[mem_addr[5:0]] = mem_data;
      end
      if (err_valid) begin
        err_seen++;
        if (exp_err.size() == 0) chk("unexpected_err", {err_valid, err_addr}, 17'h0);
        else chk("err_beat", {err_addr, err_data}, exp_err.pop_front());
      end
      if (done)    done_cnt++;
      if (reject)  reject_cnt++;
      if (timeout) timeout_cnt++;
    end
  end

  function automatic logic [79:0] all_outputs();
    return {4'b0, conv_ready, fc1_start, fc2_start, mem_we, mem_data, mem_addr,
            fc1_com_end, fc2_com_end, bck_prop_start, err_valid, err_data, err_addr,
            busy, done, reject, timeout};
  endfunction

  task automatic engine_phase(input logic [1:0] bank, input int which);
    int n;
    logic [15:0] a, d;
    n = $urandom_range(0, 3);
    tick();
    chk("kick_single", (which == 1) ? fc1_start : fc2_start, 1'b0);
    if (which == 1) fc2_done = 1'b1; else fc1_done = 1'b1;   // stray, must be ignored
    eng_addr = 16'($urandom); eng_data = 16'($urandom);
    tick();
    fc1_done = 1'b0; fc2_done = 1'b0;
    chk("phase_hold", {busy, fc1_com_end, fc2_com_end}, {1'b1, bank});
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom); d = 16'($urandom);
      eng_we = 1'b1; eng_addr = a; eng_data = d;
      exp_wr.push_back({bank, a, d});
      tick();
      eng_we = 1'b0; eng_addr = 16'($urandom);
    end
    if (which == 1) fc1_done = 1'b1; else fc2_done = 1'b1;
    tick();
    fc1_done = 1'b0; fc2_done = 1'b0;
  endtask

  // mode: 0 full step, 1 reset during BACK at count 10, 2 FC2 never completes
  task automatic run_step(input logic [3:0] lbl, input int gap_mode, input int mode);
    int d0, r0, t0, cnt;
    logic [15:0] d;
    d0 = done_cnt; r0 = reject_cnt; t0 = timeout_cnt;
    start = 1'b1; label = lbl;
    tick();
    start = 1'b0; label = 4'($urandom);
    chk("load_entry", {busy, conv_ready}, 2'b11);
    for (int i = 0; i < FRT; i++) begin
      if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
        conv_valid = 1'b0; conv_data = 16'($urandom);
        tick();
      end
      chk("beat_ready", conv_ready, 1'b1);
      d = 16'($urandom);
      conv_valid = 1'b1; conv_data = d;
      if (i == 5) begin start = 1'b1; label = 4'd15; end   // start while busy
      exp_wr.push_back({2'b00, 16'(i), d});
      tick();
      start = 1'b0;
    end
    conv_valid = 1'b0;
    chk("fc1_entry", {conv_ready, fc1_start, fc1_com_end, fc2_com_end}, 4'b0100);
    engine_phase(2'b00, 1);
    chk("fc2_entry", {fc2_start, fc1_com_end, fc2_com_end}, 3'b110);
    if (mode == 2) begin
`ifdef FC_CTRL_TIMEOUT_EN
      cnt = 0;
      while (timeout !== 1'b1 && cnt < 3 * TO) begin tick(); cnt++; end
      chk("timeout_latency", cnt, TO);
      chk("timeout_idle", {busy, bck_prop_start, fc1_com_end, fc2_com_end}, 4'b0);
      tick();
      chk("timeout_events", {done_cnt - d0, timeout_cnt - t0}, {32'd0, 32'd1});
`else
      repeat (3 * TO) tick();
      chk("stall_fc2", {busy, fc1_com_end, fc2_com_end, timeout}, 4'b1100);
      chk("stall_events", {done_cnt - d0, timeout_cnt - t0}, 64'd0);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("stall_reset", all_outputs(), 80'd0);
`endif
      return;
    end
    engine_phase(2'b10, 2);
    for (int k = 0; k < BCK; k++)
      exp_wr.push_back({2'b11, 16'(2 * BCK + k), (k == int'(lbl)) ? TGT : 16'h0000});
    chk("label_bank", {bck_prop_start, fc1_com_end, fc2_com_end}, 3'b011);
    cnt = 0;
    while (bck_prop_start !== 1'b1 && cnt < 2 * BCK) begin tick(); cnt++; end
    chk("label_len", cnt, BCK);
    for (int e = 0; e < FRT; e++) begin
      if ($urandom_range(0, 3) == 0) begin
        fc_err_addr = 16'(e) + 16'($urandom_range(1, 100));
        fc_err_prop = 16'($urandom);
        fc_bck_prop_end = 1'($urandom);
        tick();
      end
      if (mode == 1 && e == 10) begin
        fc_bck_prop_end = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        chk("abort_outputs", all_outputs(), 80'd0);
        chk("abort_queues", {exp_wr.size(), exp_err.size()}, 64'd0);
        return;
      end
      d = 16'($urandom);
      fc_err_addr = 16'(e); fc_err_prop = d;
      fc_bck_prop_end = 1'($urandom);
      exp_err.push_back({16'(e), d});
      tick();
    end
    fc_err_addr = 16'hFFFF; fc_bck_prop_end = 1'b0;
    tick();
    chk("back_wait_end", {bck_prop_start, done}, 2'b10);
    fc_bck_prop_end = 1'b1;
    tick();
    fc_bck_prop_end = 1'b0;
    chk("fin", {done, bck_prop_start, busy}, 3'b101);
    tick();
    chk("idle_after", {done, busy, fc1_com_end, fc2_com_end}, 4'b0);
    chk("step_events", {done_cnt - d0, reject_cnt - r0}, {32'd1, 32'd0});
    chk("step_queues", {exp_wr.size(), exp_err.size()}, 64'd0);
  endtask

  initial begin
    int e0;
    reset = 1'b1; start = 1'b0; label = '0; conv_valid = 1'b0; conv_data = '0;
    fc1_done = 1'b0; fc2_done = 1'b0; eng_we = 1'b0; eng_data = '0; eng_addr = '0;
    fc_bck_prop_end = 1'b0; fc_err_prop = '0; fc_err_addr = '0;
    repeat (3) tick();
    chk("reset_state", all_outputs(), 80'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    foreach (ram2[i]) ram2[i] = 16'hDEAD;
    e0 = err_seen;
    run_step(4'd3, 0, 0);
    chk("ram2_23", ram2[23], 16'h0600);
    chk("ram2_20", ram2[20], 16'h0000);
    chk("ram2_22", ram2[22], 16'h0000);
    chk("ram2_24", ram2[24], 16'h0000);
    chk("ram2_29", ram2[29], 16'h0000);
    chk("err_beats", err_seen - e0, 32'd32);

    for (int k = 0; k < 2; k++) begin
      start = 1'b1; label = (k == 0) ? 4'd12 : 4'd10;
      tick();
      start = 1'b0;
      chk("reject_pulse", {reject, busy, mem_we}, 3'b100);
      tick();
      chk("reject_clear", {reject, busy}, 2'b00);
    end
    chk("reject_count", reject_cnt, 32'd2);

    run_step(4'd9, 2, 0);
    run_step(4'd0, 1, 0);
    for (int k = 0; k < 4; k++) run_step(4'($urandom_range(0, BCK - 1)), $urandom_range(0, 2), 0);

    run_step(4'($urandom_range(0, BCK - 1)), 0, 1);
    run_step(4'd5, 0, 0);

    run_step(4'd2, 0, 2);
    run_step(4'd7, 2, 0);

    repeat (2) tick();
    chk("final_queues", {exp_wr.size(), exp_err.size()}, 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    miscompares++;
    $display("FAIL global_time_limit: run did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "time limit");
  end

endmodule
